// File: rtl/vliw_wb_arbiter_pkg.sv
// Shared configuration for the VLIW writeback arbiter: core config type,
// default lane/port/depth counts, buffer entry layout and a wrap helper.
package vliw_wb_arbiter_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned NLANES      = 4;
    localparam int unsigned NWP         = 2;
    localparam int unsigned WBBUF_DEPTH = 4;

    typedef struct packed {
        int unsigned XLEN;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{XLEN: XLEN};

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wbentry_t;

    // Pointer arithmetic modulo the buffer depth (depth need not be a power of 2)
    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned depth);
        return (base + off) % depth;
    endfunction

endpackage

// File: rtl/wb_bundle_filter.sv
// Combinational lane request filter: drops x0 writes, resolves intra-bundle
// duplicate rd in favour of the highest lane, and packs survivors to slot 0.
module wb_bundle_filter #(
    parameter int unsigned NLANES = 4,
    parameter int unsigned XL     = 32
) (
    input  logic [NLANES-1:0]         lane_we,
    input  logic [NLANES-1:0][4:0]    lane_rd,
    input  logic [NLANES-1:0][XL-1:0] lane_data,
    output logic [NLANES-1:0]         req_vld_c,
    output logic [NLANES-1:0][4:0]    req_rd_c,
    output logic [NLANES-1:0][XL-1:0] req_data_c
);

    logic [NLANES-1:0] keep;

    // A lane survives if it writes a nonzero rd that no higher lane also writes
    always_comb begin
        keep = '0;
        for (int i = 0; i < NLANES; i++) begin
            keep[i] = lane_we[i] && (lane_rd[i] != 5'd0);
            for (int j = i + 1; j < NLANES; j++) begin
                if (lane_we[j] && (lane_rd[j] == lane_rd[i])) keep[i] = 1'b0;
            end
        end
    end

    // Compact surviving lanes toward slot 0, preserving lane order
    always_comb begin
        int pos;
        req_vld_c  = '0;
        req_rd_c   = '0;
        req_data_c = '0;
        pos        = 0;
        for (int i = 0; i < NLANES; i++) begin
            if (keep[i]) begin
                for (int o = 0; o < NLANES; o++) begin
                    if (pos == o) begin
                        req_vld_c[o]  = 1'b1;
                        req_rd_c[o]   = lane_rd[i];
                        req_data_c[o] = lane_data[i];
                    end
                end
                pos++;
            end
        end
    end

endmodule

// File: rtl/vliw_wb_arbiter.sv
// VLIW writeback arbiter: age-ordered write buffer between NLANES IEU lanes
// and NWP register-file write ports, with Decode-stage forwarding lookup.
// Optional feature macro: VLIW_WB_COALESCE_EN (in-place rd coalescing).
module vliw_wb_arbiter #(
    parameter vliw_wb_arbiter_pkg::cvw_t P = vliw_wb_arbiter_pkg::CVW_DEFAULT,
    parameter int unsigned NLANES = vliw_wb_arbiter_pkg::NLANES,
    parameter int unsigned NWP    = vliw_wb_arbiter_pkg::NWP,
    parameter int unsigned DEPTH  = vliw_wb_arbiter_pkg::WBBUF_DEPTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NLANES-1:0]                   LaneWeW,
    input  logic [NLANES-1:0][4:0]              LaneRdW,
    input  logic [NLANES-1:0][P.XLEN-1:0]       LaneResultW,
    output logic                                WbStallW,
    output logic [NWP-1:0]                      we3,
    output logic [NWP-1:0][4:0]                 a3,
    output logic [NWP-1:0][P.XLEN-1:0]          wd3,
    input  logic [2*NLANES-1:0][4:0]            LookupAdr,
    output logic [2*NLANES-1:0]                 LookupHit,
    output logic [2*NLANES-1:0][P.XLEN-1:0]     LookupData
);
    import vliw_wb_arbiter_pkg::*;

    localparam int unsigned XL = P.XLEN;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    wbentry_t        ent_q [DEPTH];
    wbentry_t        ent_d [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [NLANES-1:0]         req_vld;
    logic [NLANES-1:0][4:0]    req_rd;
    logic [NLANES-1:0][XL-1:0] req_data;

    logic [DEPTH-1:0] draining;
    int unsigned      n_drain;

`ifdef VLIW_WB_COALESCE_EN
    logic [NLANES-1:0] co_hit;
    logic [PW-1:0]     co_idx [NLANES];
`endif

    wb_bundle_filter #(
        .NLANES (NLANES),
        .XL     (XL)
    ) u_filter (
        .lane_we    (LaneWeW),
        .lane_rd    (LaneRdW),
        .lane_data  (LaneResultW),
        .req_vld_c  (req_vld),
        .req_rd_c   (req_rd),
        .req_data_c (req_data)
    );

    // Drain oldest entries onto ports in order; stop before a repeated rd
    always_comb begin
        logic [PW-1:0] idx;
        logic          stop;
        we3      = '0;
        a3       = '0;
        wd3      = '0;
        draining = '0;
        n_drain  = 0;
        stop     = 1'b0;
        for (int k = 0; k < NWP; k++) begin
            idx = PW'(wrap_add(32'(head_q), k, DEPTH));
            if (!stop && (32'(k) < 32'(count_q))) begin
                for (int m = 0; m < k; m++) begin
                    if (a3[m] == ent_q[idx].rd) stop = 1'b1;
                end
                if (!stop) begin
                    we3[k]        = 1'b1;
                    a3[k]         = ent_q[idx].rd;
                    wd3[k]        = XL'(ent_q[idx].data);
                    draining[idx] = 1'b1;
                    n_drain++;
                end
            end
        end
    end

    // Acceptance decision (all-or-nothing) and next buffer state
    always_comb begin
        logic [PW-1:0] idx;
        int unsigned   n_slots;
        int unsigned   slot;
        ent_d   = ent_q;
        head_d  = PW'(wrap_add(32'(head_q), n_drain, DEPTH));
        tail_d  = tail_q;
        count_d = CW'(32'(count_q) - n_drain);
        n_slots = 0;
        slot    = 0;
        idx     = '0;
`ifdef VLIW_WB_COALESCE_EN
        co_hit = '0;
        for (int j = 0; j < NLANES; j++) co_idx[j] = '0;
        for (int j = 0; j < NLANES; j++) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = PW'(wrap_add(32'(head_q), k, DEPTH));
                if (req_vld[j] && (32'(k) < 32'(count_q)) && ent_q[idx].valid &&
                    !draining[idx] && (ent_q[idx].rd == req_rd[j])) begin
                    co_hit[j] = 1'b1;
                    co_idx[j] = idx;
                end
            end
            if (req_vld[j] && !co_hit[j]) n_slots++;
        end
`else
        for (int j = 0; j < NLANES; j++) begin
            if (req_vld[j]) n_slots++;
        end
`endif
        WbStallW = reset && ((32'(count_q) - n_drain + n_slots) > DEPTH);

        for (int d = 0; d < DEPTH; d++) begin
            if (draining[d]) ent_d[d].valid = 1'b0;
        end

        if (!WbStallW) begin
            for (int j = 0; j < NLANES; j++) begin
                if (req_vld[j]) begin
`ifdef VLIW_WB_COALESCE_EN
                    if (co_hit[j]) ent_d[co_idx[j]].data = XLEN'(req_data[j]);
                    else
`endif
                    begin
                        idx        = PW'(wrap_add(32'(tail_q), slot, DEPTH));
                        ent_d[idx] = '{valid: 1'b1, rd: req_rd[j], data: XLEN'(req_data[j])};
                        slot++;
                    end
                end
            end
            tail_d  = PW'(wrap_add(32'(tail_q), n_slots, DEPTH));
            count_d = CW'(32'(count_q) - n_drain + n_slots);
        end
    end

    // Forwarding lookup: youngest valid match wins; x0 never hits
    always_comb begin
        logic [PW-1:0] idx;
        LookupHit  = '0;
        LookupData = '0;
        for (int p = 0; p < 2 * NLANES; p++) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = PW'(wrap_add(32'(head_q), k, DEPTH));
                if ((LookupAdr[p] != 5'd0) && (32'(k) < 32'(count_q)) &&
                    ent_q[idx].valid && (ent_q[idx].rd == LookupAdr[p])) begin
                    LookupHit[p]  = 1'b1;
                    LookupData[p] = XL'(ent_q[idx].data);
                end
            end
        end
    end

    // Buffer state registers; reset discards all pending writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int d = 0; d < DEPTH; d++) ent_q[d] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int d = 0; d < DEPTH; d++) ent_q[d] <= ent_d[d];
        end
    end

endmodule
